// File: rtl/nn_result_sequencer.sv
// ---------------------------------------------------------------------------
// nn_result_sequencer
// Avalon-MM slave that runs one neural-network inference per CPU request.
// A CTRL write with bit0 set pulses nn_start, then the block waits for
// nn_done (or gives up after TIMEOUT cycles). Each result is pushed into a
// small FIFO so the HPS can collect several results in one go.
//
// Ports
//   clk        in   1       system clock
//   reset      in   1       synchronous, active-high reset
//   address    in   2       Avalon word address
//   read       in   1       Avalon read strobe
//   write      in   1       Avalon write strobe
//   writedata  in   32      Avalon write data
//   readdata   out  32      Avalon read data, registered (valid cycle after read)
//   irq        out  1       level interrupt: irq_en & ~empty
//   nn_start   out  1       one-cycle start pulse to the NN core
//   nn_done    in   1       NN core completion pulse, nn_result valid with it
//   nn_result  in   DATA_W  NN classification output
//
// Register map
//   a0 R  RESULT  pops FIFO head; [DATA_W-1:0] data, [31] valid
//   a1 R  STATUS  [0] busy [1] empty [2] full [3] overflow [4] timeout
//                 [8 +: log2(DEPTH)+1] count
//   a1 W  write-1-clear: bit3 overflow, bit4 timeout
//   a2 W  CTRL    bit0 start (not stored), bit1 irq_en
//   a2 R  {30'b0, irq_en, 1'b0}
//   a3    reads 0, writes ignored
// ---------------------------------------------------------------------------
module nn_result_sequencer #(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic              nn_start,
  input  logic              nn_done,
  input  logic [DATA_W-1:0] nn_result
);

  localparam int AW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT);
  localparam logic [CW-1:0] WCNT_ONE   = CW'(1);
  localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [CW-1:0]         wait_cnt_r;
  logic [CW-1:0]         wait_cnt_nxt_s;
  logic                  latch_en_s;
  logic                  timeout_set_s;
  logic [DATA_W-1:0]     result_latch_r;

  logic [DATA_W-1:0]     mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [AW:0]           count_r;
  logic [AW:0]           count_nxt_s;

  logic                  overflow_r;
  logic                  overflow_nxt_s;
  logic                  timeout_r;
  logic                  timeout_nxt_s;
  logic                  irq_en_r;
  logic                  irq_en_nxt_s;
  logic                  irq_r;
  logic                  nn_start_r;
  logic [31:0]           readdata_r;
  logic [31:0]           rd_data_s;

  logic                  empty_s;
  logic                  full_s;
  logic                  busy_s;
  logic                  wr_ctrl_s;
  logic                  wr_status_s;
  logic                  start_req_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  ovf_set_s;
  logic                  unused_s;

  assign empty_s     = (count_r == '0);
  assign full_s      = (count_r == DEPTH_C);
  assign busy_s      = (state_r != ST_IDLE);
  assign wr_ctrl_s   = write && (address == 2'd2);
  assign wr_status_s = write && (address == 2'd1);
  assign start_req_s = wr_ctrl_s && writedata[0];
  assign pop_s       = read && (address == 2'd0) && !empty_s;

  // A full FIFO still accepts the capture when a pop frees a slot in the
  // same cycle; only a capture into a full FIFO with no pop is dropped.
  assign push_s    = (state_r == ST_CAPTURE) && (!full_s || pop_s);
  assign ovf_set_s = (state_r == ST_CAPTURE) && full_s && !pop_s;

  assign unused_s = ^{writedata[31:5], writedata[2]};

  assign readdata = readdata_r;
  assign irq      = irq_r;
  assign nn_start = nn_start_r;

  // Sequencer next-state, wait counter and result-latch enable
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    latch_en_s     = 1'b0;
    timeout_set_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_req_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        wait_cnt_nxt_s = '0;
        state_nxt_s    = ST_WAIT;
      end
      ST_WAIT: begin
        if (nn_done) begin
          latch_en_s  = 1'b1;
          state_nxt_s = ST_CAPTURE;
        end else if (wait_cnt_r == TIMEOUT_C) begin
          timeout_set_s = 1'b1;
          state_nxt_s   = ST_IDLE;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + WCNT_ONE;
        end
      end
      ST_CAPTURE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FIFO occupancy, sticky flags and irq enable next values
  always_comb begin
    count_nxt_s    = count_r;
    overflow_nxt_s = overflow_r;
    timeout_nxt_s  = timeout_r;
    irq_en_nxt_s   = irq_en_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
    // Set beats a simultaneous write-1-clear.
    if (ovf_set_s) begin
      overflow_nxt_s = 1'b1;
    end else if (wr_status_s && writedata[3]) begin
      overflow_nxt_s = 1'b0;
    end else begin
      overflow_nxt_s = overflow_r;
    end
    if (timeout_set_s) begin
      timeout_nxt_s = 1'b1;
    end else if (wr_status_s && writedata[4]) begin
      timeout_nxt_s = 1'b0;
    end else begin
      timeout_nxt_s = timeout_r;
    end
    if (wr_ctrl_s) begin
      irq_en_nxt_s = writedata[1];
    end else begin
      irq_en_nxt_s = irq_en_r;
    end
  end

  // Read data mux, sampled into readdata on a read strobe
  always_comb begin
    rd_data_s = 32'd0;
    case (address)
      2'd0: begin
        if (!empty_s) begin
          rd_data_s = {1'b1, {(31 - DATA_W){1'b0}}, mem_r[rd_ptr_r]};
        end else begin
          rd_data_s = 32'd0;
        end
      end
      2'd1: begin
        rd_data_s[0]          = busy_s;
        rd_data_s[1]          = empty_s;
        rd_data_s[2]          = full_s;
        rd_data_s[3]          = overflow_r;
        rd_data_s[4]          = timeout_r;
        rd_data_s[8 +: AW+1]  = count_r;
      end
      2'd2: begin
        rd_data_s = {30'd0, irq_en_r, 1'b0};
      end
      default: begin
        rd_data_s = 32'd0;
      end
    endcase
  end

  // Control and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      wait_cnt_r     <= '0;
      result_latch_r <= '0;
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      count_r        <= '0;
      overflow_r     <= 1'b0;
      timeout_r      <= 1'b0;
      irq_en_r       <= 1'b0;
      irq_r          <= 1'b0;
      nn_start_r     <= 1'b0;
      readdata_r     <= 32'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      if (latch_en_s) begin
        result_latch_r <= nn_result;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r    <= count_nxt_s;
      overflow_r <= overflow_nxt_s;
      timeout_r  <= timeout_nxt_s;
      irq_en_r   <= irq_en_nxt_s;
      // Registered from next-state values so irq tracks irq_en & ~empty
      // without an extra cycle of lag.
      irq_r      <= irq_en_nxt_s && (count_nxt_s != '0);
      nn_start_r <= (state_nxt_s == ST_START);
      if (read) begin
        readdata_r <= rd_data_s;
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= result_latch_r;
    end
  end

endmodule

// File: tb/tb_nn_result_sequencer.sv
// ---------------------------------------------------------------------------
// tb_nn_result_sequencer
// Directed bench for nn_result_sequencer: basic run, FIFO fill/overflow,
// timeout, start-while-busy, push+pop on a full FIFO, and reset mid-run.
// ---------------------------------------------------------------------------
module tb_nn_result_sequencer;

  localparam int TIMEOUT = 1023;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic        nn_start;
  logic        nn_done;
  logic [3:0]  nn_result;

  int n_assert = 0;
  int n_fail   = 0;
  int start_pulses = 0;

  nn_result_sequencer #(
    .DATA_W(4),
    .FIFO_DEPTH(8),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq),
    .nn_start(nn_start),
    .nn_done(nn_done),
    .nn_result(nn_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count clock cycles during which nn_start is high
  always @(posedge clk) begin
    if (nn_start === 1'b1) start_pulses <= start_pulses + 1;
  end

  // Hard stop if the sequence ever stalls
  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0; writedata = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (nn_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One complete inference: start, nn_done after dly cycles, let CAPTURE finish
  task automatic run(input logic [3:0] res, input int dly, input logic irqen);
    bit seen;
    bus_write(2'd2, {30'd0, irqen, 1'b1});
    wait_start(seen);
    check("run_start_seen", {31'd0, seen}, 32'd1);
    repeat (dly) @(negedge clk);
    nn_done = 1'b1; nn_result = res;
    @(negedge clk);
    nn_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] exp_q [8];
    int s0;
    int busy_cycles;
    bit seen;
    bit was_busy;

    reset = 1'b1; address = 2'd0; read = 1'b0; write = 1'b0;
    writedata = 32'd0; nn_done = 1'b0; nn_result = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_readdata", readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_nn_start", {31'd0, nn_start}, 32'd0);
    reset = 1'b0;

    bus_read(2'd1, d); check("reset_status", d, 32'h0000_0002);
    bus_read(2'd2, d); check("reset_ctrl", d, 32'd0);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, d); check("a3_reads_zero", d, 32'd0);
    bus_read(2'd0, d); check("empty_pop", d, 32'd0);

    // T1 basic run
    s0 = start_pulses;
    run(4'h7, 3, 1'b0);
    check("t1_one_pulse", 32'(start_pulses - s0), 32'd1);
    bus_read(2'd1, d); check("t1_status", d, 32'h0000_0100);
    bus_read(2'd0, d); check("t1_result", d, 32'h8000_0007);
    bus_read(2'd1, d); check("t1_empty", d, 32'h0000_0002);

    // T2 fill with 0..8, ninth result overflows
    for (int i = 0; i < 9; i++) run(4'(i), 1, 1'b0);
    bus_read(2'd1, d); check("t2_status_full_ovf", d, 32'h0000_080C);
    check("t2_irq_disabled", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      bus_read(2'd0, d);
      check("t2_pop_order", d, 32'h8000_0000 + 32'(i));
    end
    bus_read(2'd1, d); check("t2_drained", d, 32'h0000_000A);
    bus_write(2'd1, 32'h0000_0008);
    bus_read(2'd1, d); check("t2_ovf_cleared", d, 32'h0000_0002);

    // T3 timeout with one entry already queued
    run(4'h3, 1, 1'b0);
    @(negedge clk);
    address = 2'd2; writedata = 32'd1; write = 1'b1;
    @(negedge clk);
    write = 1'b0; writedata = 32'd0; address = 2'd1; read = 1'b1;
    busy_cycles = 0; was_busy = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (readdata[0] === 1'b1) begin
        busy_cycles++; was_busy = 1'b1;
      end else if (was_busy) begin
        break;
      end
    end
    read = 1'b0;
    check("t3_busy_cycles", 32'(busy_cycles), 32'(TIMEOUT + 2));
    bus_read(2'd1, d); check("t3_status_timeout", d, 32'h0000_0110);
    bus_write(2'd1, 32'h0000_0010);
    bus_read(2'd1, d); check("t3_timeout_cleared", d, 32'h0000_0100);
    bus_read(2'd0, d); check("t3_fifo_unchanged", d, 32'h8000_0003);

    // T4 second start during WAIT is ignored
    s0 = start_pulses;
    bus_write(2'd2, 32'd1);
    wait_start(seen);
    check("t4_start_seen", {31'd0, seen}, 32'd1);
    bus_write(2'd2, 32'd1);
    nn_done = 1'b1; nn_result = 4'hC;
    @(negedge clk);
    nn_done = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_one_pulse", 32'(start_pulses - s0), 32'd1);
    bus_read(2'd1, d); check("t4_one_entry", d, 32'h0000_0100);
    bus_read(2'd0, d); check("t4_result", d, 32'h8000_000C);

    // T5 pop in the same cycle as CAPTURE on a full FIFO
    for (int i = 0; i < 8; i++) run(4'(8 + i), 1, 1'b0);
    bus_read(2'd1, d); check("t5_full", d, 32'h0000_0804);
    bus_write(2'd2, 32'd1);
    wait_start(seen);
    check("t5_start_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    nn_done = 1'b1; nn_result = 4'h5;
    @(negedge clk);
    nn_done = 1'b0; address = 2'd0; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    check("t5_oldest", readdata, 32'h8000_0008);
    bus_read(2'd1, d); check("t5_count_kept", d, 32'h0000_0804);
    for (int i = 0; i < 7; i++) exp_q[i] = 32'h8000_0009 + 32'(i);
    exp_q[7] = 32'h8000_0005;
    for (int i = 0; i < 8; i++) begin
      bus_read(2'd0, d);
      check("t5_drain_order", d, exp_q[i]);
    end
    bus_read(2'd1, d); check("t5_empty", d, 32'h0000_0002);

    // nn_done while idle is ignored
    nn_done = 1'b1; nn_result = 4'hE;
    @(negedge clk);
    nn_done = 1'b0;
    repeat (3) @(negedge clk);
    bus_read(2'd1, d); check("idle_done_ignored", d, 32'h0000_0002);

    // Reset while nn_start is high drops it
    bus_write(2'd2, 32'd1);
    wait_start(seen);
    check("rst_start_seen", {31'd0, seen}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_drops_start", {31'd0, nn_start}, 32'd0);
    reset = 1'b0;

    // T6 reset mid-WAIT with irq enabled and an entry queued
    bus_write(2'd2, 32'd2);
    run(4'h1, 1, 1'b1);
    check("t6_irq_set", {31'd0, irq}, 32'd1);
    bus_write(2'd2, 32'd3);
    wait_start(seen);
    check("t6_start_seen", {31'd0, seen}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; nn_done = 1'b1; nn_result = 4'hA;
    @(negedge clk);
    nn_done = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_irq_clear", {31'd0, irq}, 32'd0);
    check("t6_nn_start_low", {31'd0, nn_start}, 32'd0);
    bus_read(2'd1, d); check("t6_status", d, 32'h0000_0002);
    bus_read(2'd2, d); check("t6_irq_en_clear", d, 32'd0);
    bus_read(2'd0, d); check("t6_no_capture", d, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
